// File: rtl/axi_stream_header_arbiter.sv
// Round-robin arbiter granting one of NUM_REQ header sources to an AXI-stream insert core.
// Define HDR_ARB_TIMEOUT_EN to enable the packet watchdog (otherwise timeout is tied low).
module axi_stream_header_arbiter #(
  parameter int unsigned DATA_WD      = 32,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
  parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned TIMEOUT_CYC  = 1024
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ*DATA_WD-1:0]         req_data,
  input  logic [NUM_REQ*DATA_BYTE_WD-1:0]    req_keep,
  input  logic [NUM_REQ*BYTE_CNT_WD-1:0]     req_byte_cnt,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic                               valid_insert,
  output logic [DATA_WD-1:0]                 data_insert,
  output logic [DATA_BYTE_WD-1:0]            keep_insert,
  output logic [BYTE_CNT_WD-1:0]             byte_insert_cnt,
  input  logic                               ready_insert,
  input  logic                               valid_out,
  input  logic                               ready_out,
  input  logic                               last_out,
  output logic [$clog2(NUM_REQ)-1:0]         grant_id,
  output logic                               busy,
  output logic                               timeout
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {StIdle, StHdr, StPkt} state_e;

  state_e                  state_q, state_d;
  logic [IdW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]          grant_q, grant_d;
  logic [DATA_WD-1:0]      data_q, data_d;
  logic [DATA_BYTE_WD-1:0] keep_q, keep_d;
  logic [BYTE_CNT_WD-1:0]  cnt_q, cnt_d;

  logic [DATA_WD-1:0]      req_data_arr [NUM_REQ];
  logic [DATA_BYTE_WD-1:0] req_keep_arr [NUM_REQ];
  logic [BYTE_CNT_WD-1:0]  req_cnt_arr  [NUM_REQ];

  logic [IdW:0]            pick;
  logic                    win_found;
  logic [IdW-1:0]          win_idx;
  logic                    grant_req;
  logic                    last_hs;
  logic                    tmr_expired;

  // First valid requester at or after ptr, wrapping; MSB of the result flags a hit.
  function automatic logic [IdW:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                           input logic [IdW-1:0]     ptr);
    logic [IdW:0] res;
    int unsigned  cand;
    res = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = (int'(ptr) + off) % NUM_REQ;
      if (!res[IdW] && v[IdW'(cand)]) begin
        res = {1'b1, IdW'(cand)};
      end
    end
    return res;
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_data_arr[i] = req_data[i*DATA_WD +: DATA_WD];
      req_keep_arr[i] = req_keep[i*DATA_BYTE_WD +: DATA_BYTE_WD];
      req_cnt_arr[i]  = req_byte_cnt[i*BYTE_CNT_WD +: BYTE_CNT_WD];
    end
  end

  assign pick      = rr_pick(req_valid, rr_ptr_q);
  assign win_found = pick[IdW];
  assign win_idx   = pick[IdW-1:0];
  assign grant_req = (state_q == StIdle) && win_found;
  assign last_hs   = valid_out && ready_out && last_out;

`ifdef HDR_ARB_TIMEOUT_EN
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYC + 1);

  logic [TmrW-1:0] tmr_q, tmr_d;
  logic            timeout_q, timeout_d;

  assign tmr_expired = (state_q == StPkt) && (tmr_q == TmrW'(TIMEOUT_CYC - 1));

  always_comb begin
    tmr_d     = '0;
    timeout_d = 1'b0;
    if (state_q == StPkt) begin
      tmr_d = tmr_q + 1'b1;
    end
    // A real end-of-packet in the expiry cycle wins over the watchdog.
    if (tmr_expired && !last_hs) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmr_q     <= tmr_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign tmr_expired = 1'b0;
  assign timeout     = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    data_d   = data_q;
    keep_d   = keep_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (grant_req) begin
          state_d  = StHdr;
          rr_ptr_d = (win_idx == IdW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          grant_d  = win_idx;
          data_d   = req_data_arr[win_idx];
          keep_d   = req_keep_arr[win_idx];
          cnt_d    = req_cnt_arr[win_idx];
        end
      end
      StHdr: begin
        if (ready_insert) begin
          state_d = StPkt;
        end
      end
      StPkt: begin
        if (last_hs || tmr_expired) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      data_q   <= '0;
      keep_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      data_q   <= data_d;
      keep_q   <= keep_d;
      cnt_q    <= cnt_d;
    end
  end

  // Gated by rst so a pending request is never acknowledged while reset is held.
  assign req_ready       = (grant_req && !rst) ? (NUM_REQ'(1) << win_idx) : '0;
  assign valid_insert    = (state_q == StHdr);
  assign data_insert     = data_q;
  assign keep_insert     = keep_q;
  assign byte_insert_cnt = cnt_q;
  assign grant_id        = grant_q;
  assign busy            = (state_q != StIdle);

endmodule

// File: doc/axi_stream_header_arbiter.md
AXI_STREAM_HEADER_ARBITER -- requirements
Module: axi_stream_header_arbiter

Interface
REQ-001 Parameters SHALL be:
- DATA_WD, default 32, stream data width in bits.
- DATA_BYTE_WD, default DATA_WD/8, bytes per beat.
- BYTE_CNT_WD, default $clog2(DATA_BYTE_WD), width of the header byte count.
- NUM_REQ, default 4, number of header requesters (2..8).
- TIMEOUT_CYC, default 1024, packet watchdog limit in cycles.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, the single clock; everything is on its rising edge.
- rst, in, 1, asynchronous active-high reset.
- req_valid, in, NUM_REQ, per-requester header valid.
- req_data, in, NUM_REQ*DATA_WD, header data; slice i belongs to requester i.
- req_keep, in, NUM_REQ*DATA_BYTE_WD, header keep; slice i belongs to requester i.
- req_byte_cnt, in, NUM_REQ*BYTE_CNT_WD, header byte count; slice i belongs to requester i.
- req_ready, out, NUM_REQ, one-hot header accept.
- valid_insert, out, 1, header valid to the insert core.
- data_insert, out, DATA_WD, header data to the insert core.
- keep_insert, out, DATA_BYTE_WD, header keep to the insert core.
- byte_insert_cnt, out, BYTE_CNT_WD, header byte count to the insert core.
- ready_insert, in, 1, header accept from the insert core.
- valid_out, in, 1, output-stream monitor.
- ready_out, in, 1, output-stream monitor.
- last_out, in, 1, output-stream monitor.
- grant_id, out, $clog2(NUM_REQ), index of the current owner.
- busy, out, 1, high whenever the state is not IDLE.
- timeout, out, 1, one-cycle watchdog pulse.

Function
REQ-003 The block SHALL have three states:
- IDLE: no owner.
- HDR: header presented to the insert core.
- PKT: waiting for the end of the packet.

REQ-004 In IDLE with any req_valid bit set, the block SHALL pick the winner round-robin, searching from index rr_ptr upward with wrap-around.

REQ-005 In that same IDLE cycle:
- req_ready[winner] SHALL be high combinationally.
- All other req_ready bits SHALL be low.
- At the clock edge, the winner's data, keep and byte_cnt SHALL be registered, grant_id SHALL be set to the winner, and the state SHALL move to HDR.

REQ-006 rr_ptr SHALL load (winner+1) mod NUM_REQ on every grant.

REQ-007 In HDR:
- valid_insert SHALL be 1, driven from the registers.
- data_insert, keep_insert and byte_insert_cnt SHALL be held stable until valid_insert && ready_insert.
- On valid_insert && ready_insert, the state SHALL move to PKT.

REQ-008 Latency from an accepted request (req_ready high) to valid_insert high SHALL be exactly 1 cycle.

REQ-009 In PKT:
- valid_insert SHALL be 0.
- The state SHALL return to IDLE on the first cycle with valid_out && ready_out && last_out.

REQ-010 After a packet ends, there SHALL be exactly one IDLE cycle before the next grant; requests pending at last_out are granted in that IDLE cycle.

REQ-011 req_ready SHALL be all-zero in HDR and PKT.

REQ-012 The block SHALL ignore last_out while in IDLE or HDR.

REQ-013 If a requester drops req_valid before it is granted, the block SHALL NOT grant it.

REQ-014 With exactly one requester active, that requester SHALL be granted on every IDLE cycle regardless of rr_ptr.

REQ-015 busy SHALL be 1 exactly when the state is HDR or PKT.

Reset
REQ-016 While rst is high, all state SHALL clear asynchronously:
- state=IDLE, rr_ptr=0, grant_id=0;
- valid_insert=0, data_insert=0, keep_insert=0, byte_insert_cnt=0;
- req_ready=0, busy=0, timeout=0.

REQ-017 Reset asserted in HDR or PKT SHALL abandon the current grant; after reset, requester 0 SHALL have highest priority.

REQ-018 Outputs SHALL leave their reset values only on the first rising clk edge after rst is deasserted.

Configuration
REQ-019 Macro HDR_ARB_TIMEOUT_EN SHALL control the packet watchdog.

REQ-020 With HDR_ARB_TIMEOUT_EN defined:
- A counter SHALL clear on entry to PKT and increment each PKT cycle.
- When the counter reaches TIMEOUT_CYC-1 without a last_out handshake, the state SHALL go to IDLE and timeout SHALL pulse for 1 cycle.
- A last_out handshake in that same cycle SHALL take precedence, with no timeout pulse.

REQ-021 Without HDR_ARB_TIMEOUT_EN:
- There SHALL be no counter logic.
- timeout SHALL be tied to 0.
- PKT SHALL wait for last_out indefinitely.

Verification
REQ-022 Single request: req_valid=4'b0010, req_data[63:32]=32'hA5A5_0001, byte_cnt=2, ready_insert=1 -> req_ready=4'b0010 in cycle 0; valid_insert=1, data_insert=32'hA5A5_0001, byte_insert_cnt=2, grant_id=1 in cycle 1; state PKT in cycle 2.

REQ-023 Round-robin: req_valid=4'b1111 held, each packet ending with last_out -> grant order 0,1,2,3,0 with one IDLE cycle between packets.

REQ-024 Backpressure: ready_insert=0 for 5 cycles in HDR -> valid_insert stays 1 and data_insert stays unchanged for 5 cycles; state moves to PKT on the cycle ready_insert=1.

REQ-025 Reset mid-packet: rst=1 for 2 cycles while in PKT with grant_id=2 -> busy=0, valid_insert=0 immediately; with req_valid=4'b0101 after reset, requester 0 is granted first.

REQ-026 Timeout, with HDR_ARB_TIMEOUT_EN defined and TIMEOUT_CYC=16: enter PKT and never assert last_out -> timeout pulses once, 16 cycles after PKT entry, and the state returns to IDLE. Without the macro, busy stays 1 for 100 cycles.

REQ-027 Spurious last: last_out=1 with valid_out=1 and ready_out=1 while in HDR -> state stays HDR, no grant change.
